// File: rtl/comms_mutex_lock_master_if.sv
// Avalon-MM signal bundle between the lock master and the comms TX mutex slave.
// The slave returns zero-wait-state combinational read data.
interface comms_mutex_lock_master_if;
   logic        m_address;
   logic        m_chipselect;
   logic        m_write;
   logic        m_read;
   logic [31:0] m_writedata;
   logic [31:0] m_readdata;

   modport master (
      output m_address,
      output m_chipselect,
      output m_write,
      output m_read,
      output m_writedata,
      input  m_readdata
   );

   modport slave (
      input  m_address,
      input  m_chipselect,
      input  m_write,
      input  m_read,
      input  m_writedata,
      output m_readdata
   );
endinterface

// File: rtl/comms_mutex_lock_master.sv
// Hardware requester for the comms TX mutex: write/read-back acquire with exponential
// back-off, hold while lock_req_i is high, release write on drop.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// IDLE      | no bus activity, back-off length and retry count re-armed
// WRITE     | acquire write {OWNER_ID, LOCK_VALUE} to address 0
// READ      | read back address 0 and compare against our acquire word
// BACKOFF   | wait the current back-off length before the next attempt
// LOCKED    | mutex held, lock_granted_o high
// RELEASE   | write {OWNER_ID, 16'h0000} to free the mutex
// FAIL_WAIT | retry budget spent, wait for lock_req_i to drop
module comms_mutex_lock_master #(
   parameter logic [15:0] OWNER_ID     = 16'h0001,
   parameter logic [15:0] LOCK_VALUE   = 16'h0001,
   parameter int unsigned BACKOFF_INIT = 4,
   parameter int unsigned BACKOFF_MAX  = 256,
   parameter int unsigned MAX_RETRIES  = 0
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              lock_req_i,
   output logic                              lock_granted_o,
   output logic                              lock_fail_o,
   output logic                              busy_o,
   comms_mutex_lock_master_if.master         bus
);

   localparam logic [15:0] BO_INIT   = 16'(BACKOFF_INIT);
   localparam logic [15:0] BO_MAX    = 16'(BACKOFF_MAX);
   localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRIES);
   localparam logic [31:0] ACQ_WORD  = {OWNER_ID, LOCK_VALUE};
   localparam logic [31:0] REL_WORD  = {OWNER_ID, 16'h0000};

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_BACKOFF,
      S_LOCKED,
      S_RELEASE,
      S_FAIL_WAIT
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] bo_len_q, bo_len_d;
   logic [15:0] bo_cnt_q, bo_cnt_d;
   logic [7:0]  retry_q, retry_d;
   logic        cs_q, cs_d;
   logic        wr_q, wr_d;
   logic        rd_q, rd_d;
   logic [31:0] wdata_q, wdata_d;
   logic        granted_q, granted_d;
   logic        fail_q, fail_d;
   logic        busy_q, busy_d;

   logic [7:0]  retry_inc;
   logic [16:0] bo_dbl;
   logic [15:0] bo_len_next;

   assign retry_inc   = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
   assign bo_dbl      = {bo_len_q, 1'b0};
   assign bo_len_next = (bo_dbl > {1'b0, BO_MAX}) ? BO_MAX : bo_dbl[15:0];

   always_comb begin
      state_d  = state_q;
      bo_len_d = bo_len_q;
      bo_cnt_d = bo_cnt_q;
      retry_d  = retry_q;

      case (state_q)
         S_IDLE: begin
            bo_len_d = BO_INIT;
            retry_d  = 8'd0;
            if (lock_req_i) state_d = S_WRITE;
         end
         S_WRITE: state_d = S_READ;
         S_READ: begin
            if (bus.m_readdata == ACQ_WORD) begin
               // A lock won after a cancel is released straight away, never leaked.
               state_d = lock_req_i ? S_LOCKED : S_RELEASE;
            end else begin
               retry_d = retry_inc;
               if (!lock_req_i) begin
                  state_d = S_IDLE;
               end else if (RETRY_MAX != 8'd0 && retry_inc == RETRY_MAX) begin
                  state_d = S_FAIL_WAIT;
               end else begin
                  state_d  = S_BACKOFF;
                  bo_cnt_d = bo_len_q;
                  bo_len_d = bo_len_next;
               end
            end
         end
         S_BACKOFF: begin
            bo_cnt_d = bo_cnt_q - 16'd1;
            if (!lock_req_i)             state_d = S_IDLE;
            else if (bo_cnt_q == 16'd1)  state_d = S_WRITE;
         end
         S_LOCKED:    if (!lock_req_i) state_d = S_RELEASE;
         S_RELEASE:   state_d = S_IDLE;
         S_FAIL_WAIT: if (!lock_req_i) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they register alongside it.
      cs_d      = (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_RELEASE);
      wr_d      = (state_d == S_WRITE) || (state_d == S_RELEASE);
      rd_d      = (state_d == S_READ);
      wdata_d   = (state_d == S_WRITE)   ? ACQ_WORD :
                  (state_d == S_RELEASE) ? REL_WORD : 32'h0;
      granted_d = (state_d == S_LOCKED);
      fail_d    = (state_d == S_FAIL_WAIT) && (state_q != S_FAIL_WAIT);
      busy_d    = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         bo_len_q  <= BO_INIT;
         bo_cnt_q  <= 16'd0;
         retry_q   <= 8'd0;
         cs_q      <= 1'b0;
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
         wdata_q   <= 32'h0;
         granted_q <= 1'b0;
         fail_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bo_len_q  <= bo_len_d;
         bo_cnt_q  <= bo_cnt_d;
         retry_q   <= retry_d;
         cs_q      <= cs_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         wdata_q   <= wdata_d;
         granted_q <= granted_d;
         fail_q    <= fail_d;
         busy_q    <= busy_d;
      end
   end

   // The address-1 reset flag is never touched by this block.
   assign bus.m_address      = 1'b0;
   assign bus.m_chipselect   = cs_q;
   assign bus.m_write        = wr_q;
   assign bus.m_read         = rd_q;
   assign bus.m_writedata    = wdata_q;
   assign lock_granted_o     = granted_q;
   assign lock_fail_o        = fail_q;
   assign busy_o             = busy_q;

endmodule

// File: tb/tb_comms_mutex_lock_master.sv
// Scoreboard bench: scenarios push timestamped expected events, a negedge monitor
// pops and compares every bus cycle and output edge of two lock masters.
module tb_comms_mutex_lock_master;

   localparam int BO_INIT = 4;
   localparam int BO_MAX  = 256;
   localparam int NEVER   = 32'h4000_0000;
   localparam logic [31:0] ACQ = 32'h0001_0001;
   localparam logic [31:0] REL = 32'h0001_0000;

   localparam int K_WR = 0, K_RD = 1, K_GUP = 2, K_GDN = 3, K_FAIL = 4, K_BUP = 5, K_BDN = 6;

   typedef struct {
      int          dut;
      int          kind;
      int          cyc;
      logic [31:0] data;
   } ev_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic req0 = 1'b0, req1 = 1'b0;
   logic gr0, fl0, bz0, gr1, fl1, bz1;
   logic take0 = 1'b0, take1 = 1'b0;
   int   free0_at = -1, free1_at = -1;
   logic [31:0] mtx0, mtx1;
   int   cyc = 0;
   ev_t  expq[$];
   int   n_tests = 0, n_fail = 0;
   logic prev_gr [2] = '{1'b0, 1'b0};
   logic prev_bz [2] = '{1'b0, 1'b0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   comms_mutex_lock_master_if bus0 ();
   comms_mutex_lock_master_if bus1 ();

   comms_mutex_lock_master #(
      .OWNER_ID(16'h0001), .LOCK_VALUE(16'h0001),
      .BACKOFF_INIT(BO_INIT), .BACKOFF_MAX(BO_MAX), .MAX_RETRIES(0)
   ) u_dut0 (
      .clk(clk), .reset(reset), .lock_req_i(req0),
      .lock_granted_o(gr0), .lock_fail_o(fl0), .busy_o(bz0), .bus(bus0)
   );

   comms_mutex_lock_master #(
      .OWNER_ID(16'h0001), .LOCK_VALUE(16'h0001),
      .BACKOFF_INIT(BO_INIT), .BACKOFF_MAX(BO_MAX), .MAX_RETRIES(3)
   ) u_dut1 (
      .clk(clk), .reset(reset), .lock_req_i(req1),
      .lock_granted_o(gr1), .lock_fail_o(fl1), .busy_o(bz1), .bus(bus1)
   );

   // Mutex slave model: a write takes the mutex if it is free or already ours;
   // owner 0x0002 is a competing requester driven directly by the scenarios.
   function automatic logic [31:0] mtx_next(logic [31:0] cur, logic cs, logic wr, logic ad,
                                             logic [31:0] wd, logic fr, logic tk);
      logic [31:0] nxt;
      nxt = cur;
      if (cs && wr && !ad && (cur[15:0] == 16'h0 || cur[31:16] == wd[31:16])) nxt = wd;
      else if (fr && cur[31:16] == 16'h0002) nxt = 32'h0;
      else if (tk && cur[15:0] == 16'h0) nxt = 32'h0002_0001;
      return nxt;
   endfunction

   assign bus0.m_readdata = mtx0;
   assign bus1.m_readdata = mtx1;

   always @(posedge clk) begin
      if (reset) begin
         mtx0 <= 32'h0;
         mtx1 <= 32'h0;
      end else begin
         mtx0 <= mtx_next(mtx0, bus0.m_chipselect, bus0.m_write, bus0.m_address,
                          bus0.m_writedata, cyc == free0_at, take0);
         mtx1 <= mtx_next(mtx1, bus1.m_chipselect, bus1.m_write, bus1.m_address,
                          bus1.m_writedata, cyc == free1_at, take1);
      end
   end

   function automatic string kname(int k);
      case (k)
         K_WR:    return "write";
         K_RD:    return "read";
         K_GUP:   return "grant_rise";
         K_GDN:   return "grant_fall";
         K_FAIL:  return "lock_fail";
         K_BUP:   return "busy_rise";
         K_BDN:   return "busy_fall";
         default: return "unknown";
      endcase
   endfunction

   function automatic int bo(int k);
      int b = BO_INIT;
      for (int i = 0; i < k; i++) b = (2 * b > BO_MAX) ? BO_MAX : 2 * b;
      return b;
   endfunction

   task automatic push(int dut, int kind, int c, logic [31:0] d);
      ev_t e;
      e.dut = dut; e.kind = kind; e.cyc = c; e.data = d;
      expq.push_back(e);
   endtask

   task automatic observe(int dut, int kind, logic [31:0] data);
      int idx = -1;
      ev_t e;
      for (int i = 0; i < expq.size(); i++) begin
         if (expq[i].dut == dut && expq[i].kind == kind) begin
            idx = i;
            break;
         end
      end
      n_tests++;
      if (idx < 0) begin
         n_fail++;
         $display("FAIL unexpected_%s dut%0d: got event at cycle %0d data=%h, required none",
                  kname(kind), dut, cyc, data);
      end else begin
         e = expq[idx];
         expq.delete(idx);
         if (e.cyc != cyc || e.data !== data) begin
            n_fail++;
            $display("FAIL %s dut%0d: got cycle %0d data=%h, required cycle %0d data=%h",
                     kname(kind), dut, cyc, data, e.cyc, e.data);
         end
      end
   endtask

   task automatic mon(int w, logic gr, logic fl, logic bz, logic cs, logic wr, logic rd,
                      logic ad, logic [31:0] wd);
      if (gr !== prev_gr[w]) observe(w, (gr === 1'b1) ? K_GUP : K_GDN, 32'h0);
      if (bz !== prev_bz[w]) observe(w, (bz === 1'b1) ? K_BUP : K_BDN, 32'h0);
      if (fl === 1'b1) observe(w, K_FAIL, 32'h0);
      if (cs === 1'b1 || wr === 1'b1 || rd === 1'b1) begin
         if (cs === 1'b1 && ad === 1'b0 && (wr ^ rd) === 1'b1) begin
            observe(w, (wr === 1'b1) ? K_WR : K_RD, (wr === 1'b1) ? wd : 32'h0);
         end else begin
            n_tests++;
            n_fail++;
            $display("FAIL bus_strobes dut%0d cycle %0d: got cs=%b wr=%b rd=%b addr=%b, required one strobe with cs=1 addr=0",
                     w, cyc, cs, wr, rd, ad);
         end
      end
      prev_gr[w] = gr;
      prev_bz[w] = bz;
   endtask

   always @(negedge clk) begin
      mon(0, gr0, fl0, bz0, bus0.m_chipselect, bus0.m_write, bus0.m_read,
          bus0.m_address, bus0.m_writedata);
      mon(1, gr1, fl1, bz1, bus1.m_chipselect, bus1.m_write, bus1.m_read,
          bus1.m_address, bus1.m_writedata);
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic check_empty();
      n_tests++;
      if (expq.size() != 0) begin
         n_fail++;
         foreach (expq[i])
            $display("FAIL missing_%s dut%0d: got nothing, required at cycle %0d data=%h",
                     kname(expq[i].kind), expq[i].dut, expq[i].cyc, expq[i].data);
         expq.delete();
      end
   endtask

   task automatic wait_until(int target);
      while (cyc < target) @(negedge clk);
   endtask

   // Attempt k writes in cycle w_k and reads in w_k+1; a failed one is followed by
   // bo(k) back-off cycles. An attempt wins once the mutex is free by its write cycle.
   task automatic sched(input int dut, input int w0, input int free_cyc, input int max_att,
                        output int w_last, output int b_last);
      int w = w0;
      w_last = w0;
      b_last = 0;
      for (int k = 0; k < 4096; k++) begin
         push(dut, K_WR, w, ACQ);
         push(dut, K_RD, w + 1, 32'h0);
         w_last = w;
         b_last = bo(k);
         if (w >= free_cyc) break;
         if (max_att != 0 && k + 1 >= max_att) break;
         w += 2 + bo(k);
      end
   endtask

   task automatic scen_acquire(int hold, int keep);
      int c, fc, w, b, g, d;
      fc = 0;
      if (hold > 0) begin
         take0 = 1'b1;
         fc = cyc + hold + 1;
         free0_at = cyc + hold;
         @(negedge clk);
         take0 = 1'b0;
      end
      c = cyc;
      req0 = 1'b1;
      push(0, K_BUP, c + 1, 32'h0);
      sched(0, c + 1, fc, 0, w, b);
      g = w + 2;
      push(0, K_GUP, g, 32'h0);
      d = g + keep;
      push(0, K_GDN, d + 1, 32'h0);
      push(0, K_WR, d + 1, REL);
      push(0, K_BDN, d + 2, 32'h0);
      wait_until(d);
      req0 = 1'b0;
      wait_until(d + 4);
      free0_at = -1;
      check_empty();
   endtask

   task automatic scen_cancel_backoff(int k);
      int c, w, b, d;
      take0 = 1'b1;
      @(negedge clk);
      take0 = 1'b0;
      c = cyc;
      req0 = 1'b1;
      push(0, K_BUP, c + 1, 32'h0);
      sched(0, c + 1, NEVER, k + 1, w, b);
      d = w + 2 + int'($urandom_range(0, b - 1));
      push(0, K_BDN, d + 1, 32'h0);
      wait_until(d);
      req0 = 1'b0;
      wait_until(d + 5);
      check_empty();
      free0_at = cyc;
      @(negedge clk);
      free0_at = -1;
   endtask

   task automatic scen_cancel_win();
      int c, d;
      c = cyc;
      req0 = 1'b1;
      d = c + int'($urandom_range(1, 2));
      push(0, K_BUP, c + 1, 32'h0);
      push(0, K_WR, c + 1, ACQ);
      push(0, K_RD, c + 2, 32'h0);
      push(0, K_WR, c + 3, REL);
      push(0, K_BDN, c + 4, 32'h0);
      wait_until(d);
      req0 = 1'b0;
      wait_until(c + 7);
      check_empty();
   endtask

   task automatic scen_retry_limit();
      int c, w, b, d;
      take1 = 1'b1;
      @(negedge clk);
      take1 = 1'b0;
      c = cyc;
      req1 = 1'b1;
      push(1, K_BUP, c + 1, 32'h0);
      sched(1, c + 1, NEVER, 3, w, b);
      push(1, K_FAIL, w + 2, 32'h0);
      d = w + 2 + int'($urandom_range(0, 6));
      push(1, K_BDN, d + 1, 32'h0);
      wait_until(d);
      req1 = 1'b0;
      wait_until(d + 4);
      check_empty();
      free1_at = cyc;
      @(negedge clk);
      free1_at = -1;
   endtask

   task automatic scen_reset_locked();
      int c, r;
      c = cyc;
      req0 = 1'b1;
      push(0, K_BUP, c + 1, 32'h0);
      push(0, K_WR, c + 1, ACQ);
      push(0, K_RD, c + 2, 32'h0);
      push(0, K_GUP, c + 3, 32'h0);
      r = c + 3 + int'($urandom_range(0, 5));
      push(0, K_GDN, r + 1, 32'h0);
      push(0, K_BDN, r + 1, 32'h0);
      wait_until(r);
      reset = 1'b1;
      req0 = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      chk("post_reset_granted", {31'h0, gr0}, 32'h0);
      chk("post_reset_busy", {31'h0, bz0}, 32'h0);
      chk("post_reset_strobes", {29'h0, bus0.m_chipselect, bus0.m_write, bus0.m_read}, 32'h0);
      chk("post_reset_writedata", bus0.m_writedata, 32'h0);
      wait_until(r + 4);
      check_empty();
      // Fresh contended request must restart from the initial back-off.
      scen_acquire(30, 2);
   endtask

   initial begin
      #(900_000);
      $display("FAIL watchdog: got no end of run by cycle %0d, required completion", cyc);
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_dut0_outputs", {29'h0, gr0, fl0, bz0}, 32'h0);
      chk("reset_dut0_strobes", {28'h0, bus0.m_chipselect, bus0.m_write, bus0.m_read, bus0.m_address}, 32'h0);
      chk("reset_dut0_writedata", bus0.m_writedata, 32'h0);
      chk("reset_dut1_outputs", {29'h0, gr1, fl1, bz1}, 32'h0);
      chk("reset_dut1_strobes", {28'h0, bus1.m_chipselect, bus1.m_write, bus1.m_read, bus1.m_address}, 32'h0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      scen_acquire(0, 3);
      scen_acquire(40, 2);
      scen_cancel_backoff(0);
      scen_cancel_win();
      scen_retry_limit();
      scen_reset_locked();
      scen_acquire(760, 1);

      for (int i = 0; i < 14; i++) begin
         case ($urandom_range(0, 4))
            0: scen_acquire(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 800))
                                                       : int'($urandom_range(0, 60)),
                            int'($urandom_range(0, 8)));
            1: scen_cancel_backoff(int'($urandom_range(0, 3)));
            2: scen_cancel_win();
            3: scen_retry_limit();
            default: scen_reset_locked();
         endcase
         repeat (2) @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/comms_mutex_lock_master.md
# comms_mutex_lock_master

Hardware requester for the comms TX mutex: acquires, holds and releases the mutex on behalf of a local TX engine by issuing Avalon-MM cycles directly to the mutex slave. It sits upstream of the mutex on the same bus segment and replaces the software lock/poll/unlock sequence with a bounded, back-off-driven state machine. A `lock_granted` level tells the TX engine when it owns the shared TX buffer.

## Interface
- `OWNER_ID`, 16'h0001: owner tag placed in write data [31:16]; must be nonzero and unique per requester.
- `LOCK_VALUE`, 16'h0001: value placed in write data [15:0] on acquire; must be nonzero.
- `BACKOFF_INIT`, 4: first back-off length in cycles, 1..65535.
- `BACKOFF_MAX`, 256: back-off saturation value, ≥ `BACKOFF_INIT`, ≤ 65535.
- `MAX_RETRIES`, 0: number of failed attempts before `lock_fail` is raised; 0 means retry forever; max 255.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `lock_req`  in  1  level from the TX engine: high = want/hold lock, low = release/cancel.
- `lock_granted`  out  1  high while the mutex is held by `OWNER_ID`.
- `lock_fail`  out  1  one-cycle pulse when `MAX_RETRIES` is exhausted.
- `busy`  out  1  high in every state except IDLE.
- `m_address`  out  1  mutex slave address: 0 = mutex register, 1 = reset flag.
- `m_chipselect`  out  1  slave select.
- `m_write`  out  1  write strobe.
- `m_read`  out  1  read strobe.
- `m_writedata`  out  32  {owner[15:0], value[15:0]}.
- `m_readdata`  in  32  zero-wait-state combinational read data from the slave.

## Operation
- Moore FSM. All bus outputs are decoded from the registered state. No outputs depend combinationally on inputs.
- States:
  - IDLE, WRITE, READ, BACKOFF, LOCKED, RELEASE, FAIL_WAIT.
- IDLE:
  - All bus strobes are 0.
  - If `lock_req` is high, go to WRITE.
  - The back-off length register is set to `BACKOFF_INIT` and the retry counter is cleared.
- WRITE:
  - One cycle with `m_chipselect`=1, `m_write`=1, `m_address`=0, `m_writedata`={OWNER_ID, LOCK_VALUE}.
  - Always goes to READ, regardless of `lock_req`.
- READ:
  - One cycle with `m_chipselect`=1, `m_read`=1, `m_address`=0. `m_readdata` is sampled in this same cycle.
  - If `m_readdata` == {OWNER_ID, LOCK_VALUE}, the lock is won:
    - go to LOCKED if `lock_req` is high;
    - otherwise go to RELEASE, so a lock won after a cancel is never leaked.
  - If the compare mismatches, the attempt failed. The retry counter increments (saturating at 255). Then, in priority order:
    - if `lock_req` is low, go to IDLE;
    - if `MAX_RETRIES` ≠ 0 and the new count == `MAX_RETRIES`, go to FAIL_WAIT;
    - otherwise go to BACKOFF, loading the counter with the current back-off length, then double the back-off length, saturating at `BACKOFF_MAX`.
- BACKOFF:
  - The counter decrements once per cycle. When the counter == 1, go to WRITE.
  - If `lock_req` is low, go to IDLE immediately; no bus cycle is issued.
- LOCKED:
  - `lock_granted`=1 and all strobes are 0.
  - When `lock_req` is low, go to RELEASE.
- RELEASE:
  - One cycle with a write to address 0, `m_writedata`={OWNER_ID, 16'h0000}. This frees the mutex.
  - Then go to IDLE.
- FAIL_WAIT:
  - `lock_fail` pulses for the first cycle only.
  - Remain in FAIL_WAIT until `lock_req` is low, then go to IDLE. No bus activity in this state.
- The address-1 reset flag is never written or read by this block.
- Reset: state = IDLE, all outputs 0 (`m_writedata` = 0), retry counter = 0, back-off length = `BACKOFF_INIT`, back-off counter = 0.
- Reset mid-operation abandons the FSM without a release write. Mutex recovery is the system reset's job, because the mutex shares the reset domain.

## Timing
- Uncontended acquire, with `lock_req` sampled high at edge N:
  - WRITE in cycle N+1;
  - READ in cycle N+2;
  - `lock_granted` high from cycle N+3.
- Release: `lock_req` sampled low in LOCKED at edge M gives the release write in cycle M+1 and IDLE in M+2. `lock_granted` falls in cycle M+1.
- Failed attempt period: 2 + backoff cycles. Back-off sequence from default parameters: 4, 8, 16, …, 256, 256, …
- Back-to-back requests: `lock_req` re-asserted while in RELEASE is seen in IDLE one cycle later. The minimum IDLE dwell is 1 cycle.
- At most one bus strobe is active per cycle. `m_read` and `m_write` are never both high.

## Test plan
- Uncontended acquire: mutex model free, `lock_req` rising.
  - Required: write 0x0001_0001 to address 0, then a read of address 0, then `lock_granted`=1 at N+3.
  - Drop `lock_req`: required write 0x0001_0000, then IDLE.
- Contention: model holds 0x0002_0001 for 40 cycles.
  - Required: attempt spacing of 6, 10, 18, 34 cycles.
  - Required: grant on the first attempt after the model frees the mutex.
- Retry limit: `MAX_RETRIES`=3, mutex permanently held by 0x0002.
  - Required: exactly 3 write/read pairs, a one-cycle `lock_fail`, `busy` held high until `lock_req` falls.
- Cancel in back-off: drop `lock_req` during BACKOFF.
  - Required: IDLE next cycle with no further bus strobes.
- Cancel after winning: drop `lock_req` during WRITE with the mutex free.
  - Required: READ matches, then a RELEASE write of 0x0001_0000; `lock_granted` never asserts.
- Reset: assert `reset` while LOCKED.
  - Required: all outputs 0 on the next cycle, no release write.
  - A fresh `lock_req` afterwards starts at back-off 4 with the retry count at 0.
